// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - multi-cycle data-memory responder for the MEM stage (optional DM_MISALIGN_EXC_EN)
module dm_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_M,
  input  logic        we_M,
  input  logic [1:0]  size_M,
  input  logic        sext_M,
  input  logic [31:0] AO_M,
  input  logic [31:0] RD2_M,
  output logic [31:0] RD_M,
  output logic        stall,
  output logic        ack,
  output logic        exc_M
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  localparam logic [3:0] LAT = 4'(LATENCY);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  we_q, sext_q;
  logic [1:0]            size_q;
  logic [31:0]           rd_q;
  logic                  exc_q;

  logic [31:0] mem [2**ADDR_WIDTH];

  logic                  idle;
  logic [ADDR_WIDTH+1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic                  cur_we, cur_sext;
  logic [1:0]            cur_size;
  logic [1:0]            off;
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0]            be;
  logic [31:0]           wd, rd_shift, load_val;
  logic                  blocked, enter_resp;
  logic                  unused_addr;

  assign unused_addr = ^AO_M[31:ADDR_WIDTH+2];

  // With LATENCY=0 the response edge is the acceptance edge, so IDLE uses live inputs.
  assign idle = (state_q == S_IDLE);
  always_comb begin
    cur_addr  = idle ? AO_M[ADDR_WIDTH+1:0] : addr_q;
    cur_wdata = idle ? RD2_M  : wdata_q;
    cur_we    = idle ? we_M   : we_q;
    cur_size  = idle ? size_M : size_q;
    cur_sext  = idle ? sext_M : sext_q;
  end

  always_comb begin
    off = 2'd0;
    be  = 4'b1111;
    case (cur_size)
      2'b00: begin off = cur_addr[1:0];        be = 4'b0001 << cur_addr[1:0]; end
      2'b01: begin off = {cur_addr[1], 1'b0};  be = 4'b0011 << {cur_addr[1], 1'b0}; end
      default: ;
    endcase
  end

`ifdef DM_MISALIGN_EXC_EN
  assign blocked = ((cur_size == 2'b01) && cur_addr[0]) ||
                   (cur_size[1] && (cur_addr[1:0] != 2'b00));
`else
  assign blocked = 1'b0;
`endif

  assign idx      = cur_addr[ADDR_WIDTH+1:2];
  assign wd       = cur_wdata << {off, 3'b000};
  assign rd_shift = mem[idx] >> {off, 3'b000};

  always_comb begin
    case (cur_size)
      2'b00:   load_val = {{24{cur_sext & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_val = {{16{cur_sext & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_IDLE: if (req_M) begin
        state_d = (LAT == 4'd0) ? S_RESP : S_BUSY;
        cnt_d   = 4'd1;
      end
      S_BUSY: if (cnt_q == LAT) state_d = S_RESP;
              else cnt_d = cnt_q + 4'd1;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = (idle && req_M) || (state_q == S_BUSY);
    ack   = (state_q == S_RESP);
  end

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      sext_q  <= 1'b0;
      rd_q    <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      if (idle && req_M) begin
        addr_q  <= AO_M[ADDR_WIDTH+1:0];
        wdata_q <= RD2_M;
        we_q    <= we_M;
        size_q  <= size_M;
        sext_q  <= sext_M;
      end
      if (enter_resp) begin
        rd_q  <= (cur_we || blocked) ? 32'd0 : load_val;
        exc_q <= blocked;
      end else if (state_q == S_RESP) begin
        exc_q <= 1'b0;
      end
    end
  end

  // Array has no reset; the reset check keeps a dropped request from committing.
  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur_we && !blocked) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
    end
  end

  assign RD_M  = rd_q;
  assign exc_M = exc_q;

endmodule
